// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - 128-bit cache line memory responder with programmable latency
// Single outstanding transaction; sticky protocol and address checks.
module line_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         proto_err,
    output logic         addr_err,
    output logic [15:0]  txn_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state_q, state_d;

    logic             op_write_q;
    logic [27:0]      addr_q;
    logic [127:0]     wdata_q;
    logic [7:0]       cnt_q;
    logic [127:0]     mem [0:DEPTH-1];

    logic             req_one;
    logic             req_both;
    logic             accept;
    logic             mismatch;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign req_one   = mem_read ^ mem_write;
    assign req_both  = mem_read & mem_write;
    assign accept    = (state_q == S_IDLE) && req_one;
    assign mem_ready = (state_q == S_RESP);
    assign wr_idx    = addr_q[IDX_W-1:0];

    // With LATENCY==1 the RESP cycle follows accept directly, so the read
    // must use the live request rather than the not-yet-latched copy.
    assign rd_en  = accept ? mem_read : ~op_write_q;
    assign rd_idx = accept ? mem_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    assign mismatch = (state_q != S_IDLE) &&
                      ((mem_read != ~op_write_q) ||
                       (mem_write != op_write_q) ||
                       (mem_addr != addr_q) ||
                       (op_write_q && (mem_wdata != wdata_q)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_one) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            mem_rdata  <= '0;
            proto_err  <= 1'b0;
            addr_err   <= 1'b0;
            txn_cnt    <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_write_q <= mem_write;
                addr_q     <= mem_addr;
                wdata_q    <= mem_wdata;
                cnt_q      <= LAT_M1;
                if ((mem_addr >> IDX_W) != '0) begin
                    addr_err <= 1'b1;
                end
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (((state_q == S_IDLE) && req_both) || mismatch) begin
                proto_err <= 1'b1;
            end

            if ((state_d == S_RESP) && rd_en) begin
                mem_rdata <= mem[rd_idx];
            end else begin
                mem_rdata <= '0;
            end

            if ((state_q == S_RESP) && (txn_cnt != 16'hFFFF)) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end

    // Line storage is never reset; a write aborted by reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_RESP) && op_write_q) begin
            mem[wr_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - directed self-checking bench for line_mem_responder
// Instance 0 uses LATENCY=4, instance 1 uses LATENCY=1.
module tb_line_mem_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         rd0 = 1'b0, wr0 = 1'b0;
    logic [27:0]  addr0 = '0;
    logic [127:0] wdata0 = '0;
    logic [127:0] rdata0;
    logic         rdy0, perr0, aerr0;
    logic [15:0]  cnt0;

    logic         rd1 = 1'b0, wr1 = 1'b0;
    logic [27:0]  addr1 = '0;
    logic [127:0] wdata1 = '0;
    logic [127:0] rdata1;
    logic         rdy1, perr1, aerr1;
    logic [15:0]  cnt1;

    int cmp_cnt = 0;
    int err_cnt = 0;

    localparam logic [127:0] VX = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] VS = 128'h6666_6666_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] VY = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    localparam logic [127:0] VZ = 128'hffff_eeee_dddd_cccc_bbbb_aaaa_9999_8888;
    localparam logic [127:0] VA = {16{8'hA5}};
    localparam logic [127:0] VB = 128'hb2b0_b2b1_b2b2_b2b3_b2b4_b2b5_b2b6_b2b7;
    localparam logic [127:0] VV = 128'hdead_beef_cafe_f00d_0bad_c0de_1234_5678;

    always #5 clk = ~clk;

    line_mem_responder #(.DEPTH(256), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0), .mem_addr(addr0),
        .mem_wdata(wdata0), .mem_rdata(rdata0), .mem_ready(rdy0), .proto_err(perr0),
        .addr_err(aerr0), .txn_cnt(cnt0)
    );

    line_mem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1), .mem_addr(addr1),
        .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_ready(rdy1), .proto_err(perr1),
        .addr_err(aerr1), .txn_cnt(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input bit r, input bit w, input logic [27:0] a,
                         input logic [127:0] d);
        if (sel) begin
            rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end else begin
            rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues one request, holds it through the RESP cycle, then drops it.
    // rc is the cycle count from request to first mem_ready, -1 on timeout.
    task automatic run_txn(input bit sel, input bit w, input logic [27:0] a,
                           input logic [127:0] d, output int rc, output logic [127:0] rdv);
        drive(sel, !w, w, a, d);
        rc  = -1;
        rdv = '0;
        for (int k = 1; k <= 20 && rc < 0; k++) begin
            tick();
            if ((sel ? rdy1 : rdy0) === 1'b1) begin
                rc  = k;
                rdv = sel ? rdata1 : rdata0;
            end
        end
        if (rc >= 0) tick();
        drive(sel, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        cmp_cnt++; if (rdy0 !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %0b want 0", rdy0); end
        cmp_cnt++; if (rdata0 !== '0) begin err_cnt++; $display("FAIL reset_rdata: got %0h want 0", rdata0); end
        cmp_cnt++; if (perr0 !== 1'b0) begin err_cnt++; $display("FAIL reset_proto_err: got %0b want 0", perr0); end
        cmp_cnt++; if (aerr0 !== 1'b0) begin err_cnt++; $display("FAIL reset_addr_err: got %0b want 0", aerr0); end
        cmp_cnt++; if (cnt0 !== 16'd0) begin err_cnt++; $display("FAIL reset_txn_cnt: got %0d want 0", cnt0); end
    endtask

    task automatic preload();
        int rc;
        logic [127:0] rdv;
        run_txn(1'b0, 1'b1, 28'd5, VX, rc, rdv);
        run_txn(1'b0, 1'b1, 28'd6, VS, rc, rdv);
        run_txn(1'b0, 1'b1, 28'd7, VY, rc, rdv);
        run_txn(1'b1, 1'b1, 28'd0, VV, rc, rdv);
        do_reset();
    endtask

    task automatic test_read_latency();
        int rc;
        logic [127:0] rdv;
        run_txn(1'b0, 1'b0, 28'd5, '0, rc, rdv);
        cmp_cnt++; if (rc !== 4) begin err_cnt++; $display("FAIL rd_latency: got %0d want 4", rc); end
        cmp_cnt++; if (rdv !== VX) begin err_cnt++; $display("FAIL rd_data: got %0h want %0h", rdv, VX); end
        cmp_cnt++; if (cnt0 !== 16'd1) begin err_cnt++; $display("FAIL rd_txn_cnt: got %0d want 1", cnt0); end
        cmp_cnt++; if (rdata0 !== '0) begin err_cnt++; $display("FAIL rd_idle_rdata: got %0h want 0", rdata0); end
    endtask

    task automatic test_write_read();
        int rc;
        logic [127:0] rdv;
        do_reset();
        run_txn(1'b0, 1'b1, 28'd3, VA, rc, rdv);
        cmp_cnt++; if (rc !== 4) begin err_cnt++; $display("FAIL wr_latency: got %0d want 4", rc); end
        cmp_cnt++; if (rdv !== '0) begin err_cnt++; $display("FAIL wr_rdata_zero: got %0h want 0", rdv); end
        tick();
        run_txn(1'b0, 1'b0, 28'd3, '0, rc, rdv);
        cmp_cnt++; if (rdv !== VA) begin err_cnt++; $display("FAIL raw_data: got %0h want %0h", rdv, VA); end
        cmp_cnt++; if (cnt0 !== 16'd2) begin err_cnt++; $display("FAIL raw_txn_cnt: got %0d want 2", cnt0); end
        cmp_cnt++; if (perr0 !== 1'b0) begin err_cnt++; $display("FAIL raw_proto_err: got %0b want 0", perr0); end
    endtask

    task automatic test_back_to_back();
        int rc;
        logic [127:0] rdv;
        run_txn(1'b0, 1'b1, 28'd9, VB, rc, rdv);
        run_txn(1'b0, 1'b0, 28'd9, '0, rc, rdv);
        cmp_cnt++; if (rc !== 4) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 4", rc); end
        cmp_cnt++; if (rdv !== VB) begin err_cnt++; $display("FAIL b2b_data: got %0h want %0h", rdv, VB); end
        cmp_cnt++; if (cnt0 !== 16'd4) begin err_cnt++; $display("FAIL b2b_txn_cnt: got %0d want 4", cnt0); end
        cmp_cnt++; if (perr0 !== 1'b0) begin err_cnt++; $display("FAIL b2b_proto_err: got %0b want 0", perr0); end
    endtask

    task automatic test_both_high();
        int readys = 0;
        drive(1'b0, 1'b1, 1'b1, 28'd5, VZ);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rdy0 === 1'b1) readys++;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        cmp_cnt++; if (readys !== 0) begin err_cnt++; $display("FAIL both_ready: got %0d want 0", readys); end
        cmp_cnt++; if (perr0 !== 1'b1) begin err_cnt++; $display("FAIL both_proto_err: got %0b want 1", perr0); end
        cmp_cnt++; if (cnt0 !== 16'd4) begin err_cnt++; $display("FAIL both_txn_cnt: got %0d want 4", cnt0); end
    endtask

    task automatic test_addr_change();
        int rc = -1;
        logic [127:0] rdv = '0;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 28'd5, '0);
        for (int k = 1; k <= 20 && rc < 0; k++) begin
            tick();
            if (k == 2) addr0 = 28'd6;
            if (rdy0 === 1'b1) begin
                rc  = k;
                rdv = rdata0;
            end
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cmp_cnt++; if (rc !== 4) begin err_cnt++; $display("FAIL chg_latency: got %0d want 4", rc); end
        cmp_cnt++; if (rdv !== VX) begin err_cnt++; $display("FAIL chg_data: got %0h want %0h", rdv, VX); end
        cmp_cnt++; if (perr0 !== 1'b1) begin err_cnt++; $display("FAIL chg_proto_err: got %0b want 1", perr0); end
    endtask

    task automatic test_reset_abort();
        int rc;
        int readys = 0;
        logic [127:0] rdv;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 28'd7, VZ);
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rdy0 === 1'b1) readys++;
        end
        cmp_cnt++; if (readys !== 0) begin err_cnt++; $display("FAIL abort_ready: got %0d want 0", readys); end
        cmp_cnt++; if (rdata0 !== '0) begin err_cnt++; $display("FAIL abort_rdata: got %0h want 0", rdata0); end
        cmp_cnt++; if (cnt0 !== 16'd0) begin err_cnt++; $display("FAIL abort_txn_cnt: got %0d want 0", cnt0); end
        cmp_cnt++; if (perr0 !== 1'b0) begin err_cnt++; $display("FAIL abort_proto_err: got %0b want 0", perr0); end
        cmp_cnt++; if (aerr0 !== 1'b0) begin err_cnt++; $display("FAIL abort_addr_err: got %0b want 0", aerr0); end
        run_txn(1'b0, 1'b0, 28'd7, '0, rc, rdv);
        cmp_cnt++; if (rdv !== VY) begin err_cnt++; $display("FAIL abort_mem_kept: got %0h want %0h", rdv, VY); end
    endtask

    task automatic test_alias_lat1();
        int rc;
        logic [127:0] rdv;
        cmp_cnt++; if (aerr1 !== 1'b0) begin err_cnt++; $display("FAIL alias_pre_addr_err: got %0b want 0", aerr1); end
        run_txn(1'b1, 1'b0, 28'h100, '0, rc, rdv);
        cmp_cnt++; if (rc !== 1) begin err_cnt++; $display("FAIL lat1_latency: got %0d want 1", rc); end
        cmp_cnt++; if (rdv !== VV) begin err_cnt++; $display("FAIL alias_data: got %0h want %0h", rdv, VV); end
        cmp_cnt++; if (aerr1 !== 1'b1) begin err_cnt++; $display("FAIL alias_addr_err: got %0b want 1", aerr1); end
        cmp_cnt++; if (perr1 !== 1'b0) begin err_cnt++; $display("FAIL lat1_proto_err: got %0b want 0", perr1); end
        cmp_cnt++; if (cnt1 !== 16'd1) begin err_cnt++; $display("FAIL lat1_txn_cnt: got %0d want 1", cnt1); end
    endtask

    initial begin
        test_reset();
        preload();
        test_read_latency();
        test_write_read();
        test_back_to_back();
        test_both_high();
        test_addr_change();
        test_reset_abort();
        do_reset();
        test_alias_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
